// File: rtl/fft_pad_serdes.sv
// fft_pad_serdes: pad-side SerDes between the pad ring and the fft core.
// RX deserialises sof-framed PAD_W-bit beats (LSB beat first) into DATA_W-bit
// samples; TX serialises core samples into framed beats through a one-entry
// hold register feeding a beat shifter. RX and TX share only clk/rst.
module fft_pad_serdes #(
   parameter int DATA_W = 34,
   parameter int PAD_W  = 17
) (
   input  logic              clk,
   input  logic              rst,
   input  logic [PAD_W-1:0]  pad_in,
   input  logic              pad_in_vld,
   input  logic              pad_in_sof,
   output logic [DATA_W-1:0] core_data_in,
   output logic              core_in_vld,
   input  logic [DATA_W-1:0] core_data_out,
   input  logic              core_out_vld,
   output logic              core_out_rdy,
   output logic [PAD_W-1:0]  pad_out,
   output logic              pad_out_vld,
   output logic              pad_out_sof,
   output logic              rx_err
);

   localparam int unsigned BEATS = (DATA_W + PAD_W - 1) / PAD_W;
   localparam int          CNT_W = (BEATS > 1) ? $clog2(BEATS) : 1;
   localparam int          SH_W  = BEATS * PAD_W;
   localparam logic [CNT_W-1:0] BEAT_LAST = CNT_W'(BEATS - 1);

   // ------------------------------------------------------------------
   // RX path
   // ------------------------------------------------------------------
   typedef enum logic {
      RX_IDLE,
      RX_COLLECT
   } rx_state_t;

   rx_state_t        rx_state_q, rx_state_d;
   logic [CNT_W-1:0] rx_cnt_q, rx_cnt_d;
   logic [CNT_W-1:0] rx_idx;
   logic             rx_store;
   logic             rx_done;
   logic             rx_err_set;
   logic [SH_W-1:0]  rx_buf_q;
   logic [SH_W-1:0]  rx_merged;

   // RX frame state register
   always_ff @(posedge clk) begin
      if (rst) begin
         rx_state_q <= RX_IDLE;
         rx_cnt_q   <= '0;
      end else begin
         rx_state_q <= rx_state_d;
         rx_cnt_q   <= rx_cnt_d;
      end
   end

   // RX next state: which beat slot to write, when a sample completes
   always_comb begin
      rx_state_d = rx_state_q;
      rx_cnt_d   = rx_cnt_q;
      rx_store   = 1'b0;
      rx_idx     = '0;
      rx_done    = 1'b0;
      rx_err_set = 1'b0;
      case (rx_state_q)
         RX_IDLE: begin
            if (pad_in_vld && pad_in_sof) begin
               rx_store = 1'b1;
               if (BEATS == 1) begin
                  rx_done = 1'b1;
               end else begin
                  rx_state_d = RX_COLLECT;
                  rx_cnt_d   = CNT_W'(1);
               end
            end
         end
         RX_COLLECT: begin
            if (pad_in_vld) begin
               rx_store = 1'b1;
               if (pad_in_sof) begin
                  // resync: partial frame dropped, this beat restarts at slot 0
                  rx_err_set = 1'b1;
                  rx_cnt_d   = CNT_W'(1);
               end else begin
                  rx_idx = rx_cnt_q;
                  if (rx_cnt_q == BEAT_LAST) begin
                     rx_done    = 1'b1;
                     rx_state_d = RX_IDLE;
                     rx_cnt_d   = '0;
                  end else begin
                     rx_cnt_d = rx_cnt_q + CNT_W'(1);
                  end
               end
            end
         end
         default: rx_state_d = RX_IDLE;
      endcase
   end

   // Assembly buffer with the current beat merged into its slot
   always_comb begin
      rx_merged = rx_buf_q;
      for (int unsigned k = 0; k < BEATS; k++) begin
         if (CNT_W'(k) == rx_idx) begin
            rx_merged[k*PAD_W +: PAD_W] = pad_in;
         end
      end
   end

   // RX datapath: buffer, completed-sample register, strobe and sticky error
   always_ff @(posedge clk) begin
      if (rst) begin
         rx_buf_q     <= '0;
         core_data_in <= '0;
         core_in_vld  <= 1'b0;
         rx_err       <= 1'b0;
      end else begin
         if (rx_store) begin
            rx_buf_q <= rx_merged;
         end
         core_in_vld <= rx_done;
         if (rx_done) begin
            core_data_in <= rx_merged[DATA_W-1:0];
         end
         if (rx_err_set) begin
            rx_err <= 1'b1;
         end
      end
   end

   // ------------------------------------------------------------------
   // TX path
   // ------------------------------------------------------------------
   logic              tx_en_q;
   logic              hold_full_q;
   logic [DATA_W-1:0] hold_q;
   logic [SH_W-1:0]   hold_ext;
   logic [SH_W-1:0]   shift_q;
   logic [CNT_W-1:0]  tx_cnt_q;
   logic              tx_last;
   logic              tx_load;
   logic              tx_acc;

   assign hold_ext = SH_W'(hold_q);
   assign tx_last  = pad_out_vld && (tx_cnt_q == BEAT_LAST);
   assign tx_load  = hold_full_q && (!pad_out_vld || tx_last);
   // hold counts as free when it is being drained into the shifter this
   // cycle, so accept and reload can overlap without a bubble
   assign core_out_rdy = tx_en_q && (!hold_full_q || tx_load);
   assign tx_acc       = core_out_vld && core_out_rdy;

   // TX hold register and beat shifter driving the output pads
   always_ff @(posedge clk) begin
      if (rst) begin
         tx_en_q     <= 1'b0;
         hold_full_q <= 1'b0;
         hold_q      <= '0;
         shift_q     <= '0;
         tx_cnt_q    <= '0;
         pad_out     <= '0;
         pad_out_vld <= 1'b0;
         pad_out_sof <= 1'b0;
      end else begin
         tx_en_q <= 1'b1;
         if (tx_acc) begin
            hold_q      <= core_data_out;
            hold_full_q <= 1'b1;
         end else if (tx_load) begin
            hold_full_q <= 1'b0;
         end
         if (tx_load) begin
            pad_out     <= hold_ext[PAD_W-1:0];
            pad_out_vld <= 1'b1;
            pad_out_sof <= 1'b1;
            shift_q     <= hold_ext >> PAD_W;
            tx_cnt_q    <= '0;
         end else if (pad_out_vld && !tx_last) begin
            pad_out     <= shift_q[PAD_W-1:0];
            pad_out_sof <= 1'b0;
            shift_q     <= shift_q >> PAD_W;
            tx_cnt_q    <= tx_cnt_q + CNT_W'(1);
         end else begin
            pad_out     <= '0;
            pad_out_vld <= 1'b0;
            pad_out_sof <= 1'b0;
            shift_q     <= '0;
            tx_cnt_q    <= '0;
         end
      end
   end

endmodule

// File: doc/fft_pad_serdes.md
Name: fft_pad_serdes

Overview:
Parametrised pad-side I/O engine for the FFT chip top level. It replaces one-pad-per-bit sample transfer with a time-multiplexed PAD_W-bit pad bus.
- RX path: deserialises framed pad beats into full DATA_W-bit samples for the fft core.
- TX path: serialises core output samples into framed pad beats.
- Sits between the pad cells and the fft core, so pad count is set by PAD_W instead of DATA_W.

Parameters:
DATA_W, 34, core sample width (packed re/im), bits
PAD_W, 17, pad bus width per direction, bits; 1 <= PAD_W <= DATA_W
BEATS, ceil(DATA_W/PAD_W) (derived localparam, not overridable), beats per sample
CNT_W, max(1,clog2(BEATS)) (derived), beat counter width

Ports:
clk  in  1  single clock for all logic
rst  in  1  synchronous, active-high reset
pad_in  in  PAD_W  RX beat data from input pads
pad_in_vld  in  1  RX beat valid
pad_in_sof  in  1  RX start-of-frame, qualified by pad_in_vld; marks beat 0
core_data_in  out  DATA_W  assembled sample to fft core
core_in_vld  out  1  one-cycle strobe, core_data_in valid
core_data_out  in  DATA_W  sample from fft core
core_out_vld  in  1  core sample valid
core_out_rdy  out  1  TX can accept sample
pad_out  out  PAD_W  TX beat data to output pads
pad_out_vld  out  1  TX beat valid
pad_out_sof  out  1  TX start-of-frame (beat 0)
rx_err  out  1  sticky framing error

Behaviour:
Reset (rst=1 at a clk edge):
- All outputs go to 0: core_data_in, core_in_vld, core_out_rdy, pad_out, pad_out_vld, pad_out_sof, rx_err.
- Partial RX frames, the TX hold register and the TX shifter are discarded.
- core_out_rdy rises to 1 on the first cycle after rst deasserts.
- Reset mid-frame aborts the frame; no partial sample is ever emitted.

Beat order: beat k carries sample bits [k*PAD_W +: PAD_W], LSB beat first.
- The last beat's bits above DATA_W are don't-care on RX and driven 0 on TX.

RX FSM, states IDLE and COLLECT:
- IDLE: a valid beat without sof is dropped silently. A valid beat with sof stores beat 0 and sets cnt=1.
  - If BEATS==1, the sample is complete immediately; otherwise go to COLLECT.
- COLLECT: each valid beat without sof stores beat cnt and increments cnt.
  - On the beat with cnt==BEATS-1: register the full sample into core_data_in, pulse core_in_vld the following cycle, return to IDLE.
- COLLECT with pad_in_vld=0: hold state and contents; there is no timeout.
- COLLECT with a valid sof beat: set rx_err=1, discard the partial frame, treat the beat as beat 0 of a new frame, cnt=1.
- Latency: core_in_vld is high exactly 1 cycle after the clk edge sampling the last beat.
- core_data_in holds its value until the next completed sample.
- rx_err is sticky until rst.

TX path (hold register plus shifter):
- core_out_rdy = hold register empty.
- Accept on core_out_vld & core_out_rdy; the sample goes to the hold register.
- Shifter idle with hold full: load the shifter from the hold register, freeing hold the same cycle. The next cycle drives beat 0 with pad_out_sof=1 and pad_out_vld=1.
- Following cycles drive beats 1..BEATS-1 with pad_out_vld=1 and pad_out_sof=0; there are no pad-side stalls.
- On the cycle the last beat is driven, if hold is full, reload so the next sample's beat 0 follows with no gap.
  - Sustained throughput: one sample per BEATS cycles.
- Accept and reload in the same cycle are allowed; hold is refilled by the new sample.
- Shifter empty: pad_out_vld=0, pad_out_sof=0, pad_out=0.
- Accept-to-beat-0 latency is 2 cycles when the shifter is idle.
- BEATS==1: every accepted sample appears as one sof beat 2 cycles later, and core_out_rdy stays 1 continuously.

RX and TX are fully independent.

Test Plan:
- Reset mid-operation: DATA_W=34, PAD_W=17, rst=1 after RX beat 0 and during a TX beat 1. The next cycle has all outputs 0. After rst drops, a lone beat 1 without sof gives no core_in_vld, and core_out_rdy=1.
- RX nominal: beat0 0x05555 (sof), beat1 0x15555 on consecutive cycles. One cycle later core_in_vld=1 for exactly 1 cycle with core_data_in=0x2AAAA5555; rx_err=0.
- RX gap and resync:
  - beat0 0x00001 (sof), 3 idle cycles, beat1 0x00000 gives core_data_in=0x000000001.
  - Then beat0 (sof), beat0 (sof) 0x00003, beat1 0x00000 gives one strobe with 0x000000003 and rx_err=1.
- TX nominal: core_data_out=0x2AAAA5555 with vld=1 for 1 cycle (rdy=1). 2 cycles later pad_out=0x05555 with sof=1, then 0x15555 with sof=0, then pad_out_vld=0.
- TX back-pressure: core_out_vld held high with 4 distinct samples. Output is 8 contiguous beats with sof on every even beat. core_out_rdy pattern matches single-entry hold; no sample is lost or duplicated.
- Degenerate width: PAD_W=34. RX sof beat 0x3FFFFFFFF gives core_data_in=0x3FFFFFFFF one cycle later. TX sends one sof beat per sample and core_out_rdy stays 1.
